// File: rtl/div_issue_ctrl.sv
// Issue/capture sequencer for the EX-stage divide path: feeds the signed or unsigned divider IP,
// captures quotient or remainder, and drains in-flight results after a pipeline flush.
module div_issue_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_signed,
  input  logic                  req_mod,
  input  logic [DATA_W-1:0]     req_src1,
  input  logic [DATA_W-1:0]     req_src2,
  input  logic                  flush,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_data,
  output logic                  busy,
  output logic                  s_dvd_tvalid,
  input  logic                  s_dvd_tready,
  output logic                  s_dvs_tvalid,
  input  logic                  s_dvs_tready,
  input  logic                  s_dout_tvalid,
  input  logic [2*DATA_W-1:0]   s_dout_tdata,
  output logic                  u_dvd_tvalid,
  input  logic                  u_dvd_tready,
  output logic                  u_dvs_tvalid,
  input  logic                  u_dvs_tready,
  input  logic                  u_dout_tvalid,
  input  logic [2*DATA_W-1:0]   u_dout_tdata,
  output logic [DATA_W-1:0]     dvd_tdata,
  output logic [DATA_W-1:0]     dvs_tdata
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic                sel_signed_q, sel_signed_d;
  logic                sel_mod_q, sel_mod_d;
  logic                dvd_acc_q, dvd_acc_d;
  logic                dvs_acc_q, dvs_acc_d;
  logic                kill_q, kill_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [DATA_W-1:0]   res_q, res_d;

  logic                dvd_tv, dvs_tv;
  logic                dvd_done, dvs_done;
  logic                dvd_tready_sel, dvs_tready_sel;
  logic                dout_v_sel;
  logic [2*DATA_W-1:0] dout_sel;

  // Only the unit chosen at accept time is ever looked at.
  assign dvd_tready_sel = sel_signed_q ? s_dvd_tready  : u_dvd_tready;
  assign dvs_tready_sel = sel_signed_q ? s_dvs_tready  : u_dvs_tready;
  assign dout_v_sel     = sel_signed_q ? s_dout_tvalid : u_dout_tvalid;
  assign dout_sel       = sel_signed_q ? s_dout_tdata  : u_dout_tdata;

  always_comb begin
    state_d      = state_q;
    sel_signed_d = sel_signed_q;
    sel_mod_d    = sel_mod_q;
    dvd_acc_d    = dvd_acc_q;
    dvs_acc_d    = dvs_acc_q;
    kill_d       = kill_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    res_d        = res_q;
    dvd_tv       = 1'b0;
    dvs_tv       = 1'b0;
    dvd_done     = 1'b0;
    dvs_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          sel_signed_d = req_signed;
          sel_mod_d    = req_mod;
          dvd_d        = req_src1;
          dvs_d        = req_src2;
          dvd_acc_d    = 1'b0;
          dvs_acc_d    = 1'b0;
          kill_d       = 1'b0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // A flush cannot withdraw tvalid, so it is remembered and acted on once both beats are taken.
        dvd_tv    = !dvd_acc_q;
        dvs_tv    = !dvs_acc_q;
        dvd_done  = dvd_acc_q || dvd_tready_sel;
        dvs_done  = dvs_acc_q || dvs_tready_sel;
        dvd_acc_d = dvd_done;
        dvs_acc_d = dvs_done;
        kill_d    = kill_q || flush;
        if (dvd_done && dvs_done) begin
          state_d = (kill_q || flush) ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (dout_v_sel) begin
          if (!flush) begin
            res_d   = sel_mod_q ? dout_sel[DATA_W-1:0] : dout_sel[2*DATA_W-1:DATA_W];
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (flush || res_ready) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (dout_v_sel) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      sel_signed_q <= 1'b0;
      sel_mod_q    <= 1'b0;
      dvd_acc_q    <= 1'b0;
      dvs_acc_q    <= 1'b0;
      kill_q       <= 1'b0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      res_q        <= '0;
    end else begin
      state_q      <= state_d;
      sel_signed_q <= sel_signed_d;
      sel_mod_q    <= sel_mod_d;
      dvd_acc_q    <= dvd_acc_d;
      dvs_acc_q    <= dvs_acc_d;
      kill_q       <= kill_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      res_q        <= res_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign res_valid    = (state_q == DONE);
  assign res_data     = res_q;
  assign dvd_tdata    = dvd_q;
  assign dvs_tdata    = dvs_q;
  assign s_dvd_tvalid = dvd_tv && sel_signed_q;
  assign s_dvs_tvalid = dvs_tv && sel_signed_q;
  assign u_dvd_tvalid = dvd_tv && !sel_signed_q;
  assign u_dvs_tvalid = dvs_tv && !sel_signed_q;

endmodule
